psum_accum: RTL

PSUM_ACCUM -- requirements
Module: psum_accum

---
 rtl/psum_pkg.sv | 46 ++++
 rtl/psum_accum_if.sv | 26 ++
 rtl/psum_sram.sv | 27 ++
 rtl/psum_accum.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/psum_pkg.sv
// Shared types and lane arithmetic for the psum accumulator.
// Build option: PSUM_SAT_EN selects saturating lane sums; when it is not
// defined, lane sums wrap modulo 2^psum_bw.
package psum_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    ACC      = 2'd2,
    PASS_END = 2'd3
  } state_t;

`ifdef PSUM_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // Signed add of two sign-extended lanes of width bw (bw <= 32), then
  // saturate or wrap back into bw bits, then optionally clamp negatives to 0.
  function automatic logic signed [31:0] lane_add(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input int unsigned        bw,
    input logic               relu
  );
    logic signed [63:0] sum;
    logic signed [63:0] lim_hi;
    logic signed [63:0] lim_lo;
    logic signed [63:0] res;
    sum    = 64'(a) + 64'(b);
    lim_hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
    lim_lo = -(64'sd1 <<< (bw - 1));
    if (SAT_EN) begin
      if (sum > lim_hi)      res = lim_hi;
      else if (sum < lim_lo) res = lim_lo;
      else                   res = sum;
    end else begin
      // keep the low bw bits and sign-extend them back to full width
      res = (sum <<< (64 - bw)) >>> (64 - bw);
    end
    if (relu && (res < 0)) res = '0;
    return res[31:0];
  endfunction

endpackage

// File: rtl/psum_accum_if.sv
// Output-FIFO pop handshake and psum readout bus of the accumulator.
// master: FIFO/host side; slave: the accumulator.
interface psum_accum_if #(
  parameter int col     = 4,
  parameter int psum_bw = 16,
  parameter int num_inp = 8
);
  localparam int AW = (num_inp > 1) ? $clog2(num_inp) : 1;

  logic [col*psum_bw-1:0] ofifo_data;
  logic                   ofifo_valid;
  logic                   ofifo_rd;
  logic                   psum_rd;
  logic [AW-1:0]          psum_addr;
  logic [col*psum_bw-1:0] psum_mem_dout;

  modport master (
    output ofifo_data, ofifo_valid, psum_rd, psum_addr,
    input  ofifo_rd, psum_mem_dout
  );

  modport slave (
    input  ofifo_data, ofifo_valid, psum_rd, psum_addr,
    output ofifo_rd, psum_mem_dout
  );
endinterface

// File: rtl/psum_sram.sv
// Single-port psum storage, one access per cycle, 1-cycle read latency.
// Contents are not reset; dout holds its value between reads.
module psum_sram #(
  parameter int width = 64,
  parameter int depth = 8,
  parameter int aw    = 3
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [aw-1:0]    addr_i,
  input  logic [width-1:0] din_i,
  output logic [width-1:0] dout_o
);
  logic [width-1:0] mem_q [depth];
  logic [width-1:0] dout_q;

  // write on we_i, otherwise register the addressed word
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= din_i;
      else      dout_q        <= mem_q[addr_i];
    end
  end

  assign dout_o = dout_q;
endmodule

// File: rtl/psum_accum.sv
// Partial-sum accumulator: pops output-FIFO rows, adds them lane-wise into
// per-row storage over kij_len passes, optional ReLU on the last pass, and
// serves row readout while idle. Saturation option: see psum_pkg (PSUM_SAT_EN).
module psum_accum
  import psum_pkg::*;
#(
  parameter int col     = 4,
  parameter int psum_bw = 16,
  parameter int num_inp = 8,
  parameter int kij_len = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           relu,
  psum_accum_if.slave    bus,
  output logic           iter_done,
  output logic           compute_done
);
  localparam int AW = (num_inp > 1) ? $clog2(num_inp) : 1;
  localparam int PW = (kij_len > 1) ? $clog2(kij_len) : 1;
  localparam int DW = col * psum_bw;
  localparam logic [AW-1:0] LAST_ROW  = AW'(num_inp - 1);
  localparam logic [PW-1:0] LAST_PASS = PW'(kij_len - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   row_q, row_d;
  logic [PW-1:0]   pass_q, pass_d;
  logic            relu_q, relu_d;
  logic            done_q, done_d;
  logic            rd_pend_q, rd_pend_d;
  logic [DW-1:0]   data_q, data_d;
  logic [DW-1:0]   hold_q;
  logic [DW-1:0]   sum_w;
  logic [DW-1:0]   mem_dout;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;

  psum_sram #(
    .width (DW),
    .depth (num_inp),
    .aw    (AW)
  ) u_sram (
    .clk_i  (clk),
    .en_i   (mem_en),
    .we_i   (mem_we),
    .addr_i (mem_addr),
    .din_i  (sum_w),
    .dout_o (mem_dout)
  );

  // control and capture registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      row_q     <= '0;
      pass_q    <= '0;
      relu_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_pend_q <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      pass_q    <= pass_d;
      relu_q    <= relu_d;
      done_q    <= done_d;
      rd_pend_q <= rd_pend_d;
      data_q    <= data_d;
    end
  end

  // readout holding register; sram dout also moves during jobs, so the
  // visible readout is latched from the cycle after each readout request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         hold_q <= '0;
    else if (rd_pend_q) hold_q <= mem_dout;
  end

  assign bus.psum_mem_dout = rd_pend_q ? mem_dout : hold_q;
  assign compute_done      = done_q;

  // lane-wise sum of the captured FIFO row and the stored row
  always_comb begin
    logic signed [psum_bw-1:0] lane_new;
    logic signed [psum_bw-1:0] lane_old;
    logic signed [31:0]        lane_res;
    lane_new = '0;
    lane_old = '0;
    lane_res = '0;
    sum_w    = '0;
    for (int unsigned i = 0; i < col; i++) begin
      lane_new = data_q[i*psum_bw +: psum_bw];
      lane_old = (pass_q == '0) ? '0 : mem_dout[i*psum_bw +: psum_bw];
      lane_res = lane_add(32'(lane_new), 32'(lane_old), psum_bw,
                          relu_q && (pass_q == LAST_PASS));
      sum_w[i*psum_bw +: psum_bw] = lane_res[psum_bw-1:0];
    end
  end

  // FSM next state, memory port control and strobes
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    pass_d       = pass_q;
    relu_d       = relu_q;
    done_d       = done_q;
    data_d       = data_q;
    rd_pend_d    = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = row_q;
    bus.ofifo_rd = 1'b0;
    iter_done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          row_d   = '0;
          pass_d  = '0;
          done_d  = 1'b0;
          relu_d  = relu;
        end else if (bus.psum_rd) begin
          mem_en    = 1'b1;
          mem_addr  = bus.psum_addr;
          rd_pend_d = 1'b1;
        end
      end
      FETCH: begin
        if (bus.ofifo_valid) begin
          bus.ofifo_rd = 1'b1;
          mem_en       = 1'b1;
          data_d       = bus.ofifo_data;
          state_d      = ACC;
        end
      end
      ACC: begin
        mem_en = 1'b1;
        mem_we = 1'b1;
        if (row_q == LAST_ROW) begin
          row_d   = '0;
          state_d = PASS_END;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = FETCH;
        end
      end
      PASS_END: begin
        iter_done = 1'b1;
        pass_d    = pass_q + 1'b1;
        if (pass_q == LAST_PASS) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
